// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for sram_arbiter.
// The slave modport is the arbiter. The master modport is the environment: both requesters plus the SRAM device.
interface sram_arbiter_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
);
  // Requester A
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_done;
  logic [DW-1:0] a_rdata;
  // Requester B
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_done;
  logic [DW-1:0] b_rdata;
  // SRAM pins and status
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] sram_din;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_din,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output sram_addr, sram_dout, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_din,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  sram_addr, sram_dout, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for a shared asynchronous SRAM.
// It accepts one request at a time and runs a fixed write sequence (setup/strobe/hold) or read sequence (setup/wait/capture).
// Every pin output is registered, so an asynchronous clr_n deasserts the strobes at once.
// Define SRAM_ARB_RR_EN to get a round-robin tie-break. Without it, A has fixed priority on ties.
module sram_arbiter #(
  parameter int unsigned AW      = 18,
  parameter int unsigned DW      = 16,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic          clk,
  input  logic          clr_n,
  sram_arbiter_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_INIT = CW'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_CAP
  } state_e;

  state_e        state_q;
  logic          win_b_q;
  logic [CW-1:0] wait_q;
  logic [AW-1:0] sram_addr_q;
  logic [DW-1:0] sram_dout_q;
  logic          dq_oe_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          a_gnt_q, b_gnt_q;
  logic          a_done_q, b_done_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          busy_q;

  logic          any_req_c;
  logic          pick_b_c;
  logic          win_we_c;

`ifdef SRAM_ARB_RR_EN
  logic last_b_q;

  // Last-grant pointer; reset to B so A wins the first tie.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      last_b_q <= 1'b1;
    end else if (state_q == IDLE && any_req_c) begin
      last_b_q <= pick_b_c;
    end
  end
`endif

  // Arbitration decision, used only while in IDLE.
  always_comb begin
    any_req_c = bus.a_req | bus.b_req;
`ifdef SRAM_ARB_RR_EN
    pick_b_c  = bus.b_req & (~bus.a_req | ~last_b_q);
`else
    pick_b_c  = bus.b_req & ~bus.a_req;
`endif
    win_we_c  = pick_b_c ? bus.b_we : bus.a_we;
  end

  // Sequencer with registered SRAM strobes and handshake pulses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      win_b_q     <= 1'b0;
      wait_q      <= '0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            win_b_q     <= pick_b_c;
            sram_addr_q <= pick_b_c ? bus.b_addr : bus.a_addr;
            sram_dout_q <= pick_b_c ? bus.b_wdata : bus.a_wdata;
            a_gnt_q     <= ~pick_b_c;
            b_gnt_q     <= pick_b_c;
            busy_q      <= 1'b1;
            ce_n_q      <= 1'b0;
            if (win_we_c) begin
              state_q <= W_SETUP;
              dq_oe_q <= 1'b1;
            end else begin
              state_q <= R_SETUP;
              oe_n_q  <= 1'b0;
            end
          end
        end
        W_SETUP: begin
          state_q <= W_STROBE;
          we_n_q  <= 1'b0;
        end
        W_STROBE: begin
          state_q <= W_HOLD;
          we_n_q  <= 1'b1;
        end
        W_HOLD: begin
          state_q  <= IDLE;
          ce_n_q   <= 1'b1;
          dq_oe_q  <= 1'b0;
          busy_q   <= 1'b0;
          a_done_q <= ~win_b_q;
          b_done_q <= win_b_q;
        end
        R_SETUP: begin
          if (RD_WAIT == 0) begin
            state_q <= R_CAP;
          end else begin
            state_q <= R_WAIT;
            wait_q  <= WAIT_INIT;
          end
        end
        R_WAIT: begin
          if (wait_q == '0) begin
            state_q <= R_CAP;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        R_CAP: begin
          state_q  <= IDLE;
          ce_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
          busy_q   <= 1'b0;
          a_done_q <= ~win_b_q;
          b_done_q <= win_b_q;
          if (win_b_q) begin
            b_rdata_q <= bus.sram_din;
          end else begin
            a_rdata_q <= bus.sram_din;
          end
        end
        default: begin
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.a_done     = a_done_q;
  assign bus.b_done     = b_done_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_dout  = sram_dout_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: the main DUT uses RD_WAIT=1 and a second instance uses RD_WAIT=0.
module tb_sram_arbiter;
  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 16;
  localparam int unsigned RDW = 1;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sram_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  sram_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(RDW)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );
  sram_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .bus(bus0)
  );

  // SRAM device model: 256 words, aliased on the low address byte.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(32'h5A00 ^ i);
    mem[8'h10] = 16'h1234;
    forever begin
      @(posedge clk);
      if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr[7:0]] = bus.sram_dout;
    end
  end
  assign bus.sram_din  = bus.sram_oe_n ? 16'hDEAD : mem[bus.sram_addr[7:0]];
  assign bus0.sram_din = bus0.sram_oe_n ? 16'h0000 : (bus0.sram_addr[15:0] ^ 16'h0F0F);

  typedef struct packed {
    logic          port;   // 0 = A, 1 = B
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          sb[$];
  int            sb_rd = 0;
  logic [DW-1:0] shadow [256];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Protocol and scoreboard monitor, sampled on the falling edge.
  task automatic monitor();
    int   gnt_cyc = 0;
    int   we_low  = 0;
    int   we_cyc  = 0;
    int   oe_low  = 0;
    int   dq_cnt  = 0;
    logic active  = 1'b0;
    txn_t t       = '0;
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        active = 1'b0;
        sb_rd  = sb.size();
        continue;
      end
      chk("bus_conflict", 32'(bus.sram_dq_oe & ~bus.sram_oe_n), 32'd0);
      if (bus.a_gnt | bus.b_gnt) begin
        chk("gnt_with_done", 32'(bus.a_done | bus.b_done), 32'd0);
        if (active || sb_rd >= sb.size()) begin
          chk("gnt_unexpected", 32'({bus.a_gnt, bus.b_gnt}), 32'd0);
        end else begin
          t = sb[sb_rd];
          chk("gnt_port", 32'({bus.a_gnt, bus.b_gnt}), t.port ? 32'd1 : 32'd2);
          active  = 1'b1;
          gnt_cyc = cyc;
          we_low  = 0;
          oe_low  = 0;
          dq_cnt  = 0;
        end
      end
      if (active) begin
        if (!bus.sram_we_n) begin we_low++; we_cyc = cyc; end
        if (!bus.sram_oe_n) oe_low++;
        if (bus.sram_dq_oe) dq_cnt++;
        chk("addr_stable", 32'(bus.sram_addr), 32'(t.addr));
        if (t.we) chk("dout_stable", 32'(bus.sram_dout), 32'(t.wdata));
        if (bus.a_done | bus.b_done) begin
          chk("done_port", 32'({bus.a_done, bus.b_done}), t.port ? 32'd1 : 32'd2);
          chk("done_latency", 32'(cyc - gnt_cyc), t.we ? 32'd3 : 32'(2 + RDW));
          chk("busy_at_done", 32'(bus.busy), 32'd0);
          chk("dq_oe_cycles", 32'(dq_cnt), t.we ? 32'd3 : 32'd0);
          if (t.we) begin
            chk("we_n_low_cycles", 32'(we_low), 32'd1);
            chk("we_n_position", 32'(we_cyc - gnt_cyc), 32'd1);
          end else begin
            chk("oe_n_low_cycles", 32'(oe_low), 32'(2 + RDW));
            chk("rdata", 32'(t.port ? bus.b_rdata : bus.a_rdata), 32'(t.rdata));
          end
          active = 1'b0;
          sb_rd++;
        end else begin
          chk("busy_in_seq", 32'(bus.busy), 32'd1);
        end
      end else if (bus.a_done | bus.b_done) begin
        chk("done_unexpected", 32'({bus.a_done, bus.b_done}), 32'd0);
      end
    end
  endtask

  function automatic txn_t mk_txn(input logic port, input logic we,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wd;
    t.rdata = we ? '0 : shadow[addr[7:0]];
    if (we) shadow[addr[7:0]] = wd;
    return t;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (sb_rd < sb.size() && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size() - sb_rd), 32'd0);
  endtask

  task automatic issue(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic wait_done);
    int   n = 0;
    logic g;
    sb.push_back(mk_txn(port, we, addr, wd));
    @(negedge clk);
    if (port) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    do begin
      @(negedge clk);
      n++;
      g = port ? bus.b_gnt : bus.a_gnt;
    end while (!g && n < 20);
    chk("gnt_seen", 32'(g), 32'd1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g0;
    int d0;
    logic [DW-1:0] ev;
    for (int i = 0; i < 256; i++) shadow[i] = DW'(32'h5A00 ^ i);
    shadow[8'h10] = 16'h1234;
    {bus.a_req, bus.a_we, bus.a_addr, bus.a_wdata} = '0;
    {bus.b_req, bus.b_we, bus.b_addr, bus.b_wdata} = '0;
    {bus0.a_req, bus0.a_we, bus0.a_addr, bus0.a_wdata} = '0;
    {bus0.b_req, bus0.b_we, bus0.b_addr, bus0.b_wdata} = '0;
    fork monitor(); join_none

    #1 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}), 32'hE);
    chk("rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_dout", 32'(bus.sram_dout), 32'd0);
    chk("rst_hs", 32'({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.busy}), 32'd0);
    chk("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
    @(negedge clk) clr_n = 1'b1;

    // Abort a write during W_STROBE.
    issue(1'b0, 1'b1, 18'h00077, 16'hBEEF, 1'b0);
    n = 0;
    while (bus.sram_we_n && n < 10) begin @(negedge clk); n++; end
    chk("reach_w_strobe", 32'(bus.sram_we_n), 32'd0);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({bus.sram_ce_n, bus.sram_we_n, bus.sram_dq_oe}), 32'h6);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.a_done | bus.b_done), 32'd0);
    end
    clr_n = 1'b1;

    issue(1'b0, 1'b1, 18'h3FFFF, 16'hA5A5, 1'b1);
    issue(1'b1, 1'b0, 18'h00010, 16'h0000, 1'b1);
    issue(1'b0, 1'b1, 18'h00042, 16'h0001, 1'b1);
    issue(1'b0, 1'b0, 18'h00042, 16'h0000, 1'b1);
    issue(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 1'b1);
    issue(1'b1, 1'b1, 18'h00033, 16'h5EED, 1'b1);
    issue(1'b0, 1'b0, 18'h00033, 16'h0000, 1'b1);

    // Both ports requesting continuously after reset.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_RR_EN
      sb.push_back(mk_txn(1'(k % 2), 1'b0, (k % 2 == 1) ? 18'h00021 : 18'h00020, 16'h0));
`else
      sb.push_back(mk_txn(1'b0, 1'b0, 18'h00020, 16'h0));
`endif
    end
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = 18'h00020; bus.a_req = 1'b1;
    bus.b_we = 1'b0; bus.b_addr = 18'h00021; bus.b_req = 1'b1;
    n = 0;
    g0 = 0;
    while (g0 < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.a_gnt | bus.b_gnt) g0++;
    end
    chk("tie_grants", 32'(g0), 32'd6);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    wait_idle();

    // RD_WAIT=0 instance: read completes in cycle 3.
    ev = 16'h0055 ^ 16'h0F0F;
    @(negedge clk);
    bus0.b_we = 1'b0; bus0.b_addr = 18'h00055; bus0.b_req = 1'b1;
    n = 0;
    while (!bus0.b_gnt && n < 20) begin @(negedge clk); n++; end
    chk("rw0_gnt", 32'(bus0.b_gnt), 32'd1);
    g0 = cyc;
    bus0.b_req = 1'b0;
    n = 0;
    while (!bus0.b_done && n < 20) begin @(negedge clk); n++; end
    d0 = cyc;
    chk("rw0_done", 32'(bus0.b_done), 32'd1);
    chk("rw0_latency", 32'(d0 - g0), 32'd2);
    chk("rw0_rdata", 32'(bus0.b_rdata), 32'(ev));
    chk("rw0_a_quiet", 32'({bus0.a_gnt, bus0.a_done}), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
